// File: rtl/spi_slave_par.sv
// Serial slave with oversampled sck, all four CPOL/CPHA modes, configurable width/bit order,
// full-duplex back-to-back words and a one-entry transmit holding buffer.
module spi_slave_par #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             mosi,
    input  logic             cs_n,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic sck_hist, cs_hist;
    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge;

    logic [CW-1:0]    cnt, cnt_after;
    logic [WIDTH-1:0] rx_shift, rx_next, tx_shift, tx_buf;
    logic             tx_full, load_pend;
    logic             active, do_sample, word_done, go_active, go_idle;
    logic             shift_act, do_load, do_shift, frame_abort;

    // The cs_n chain resets low so a cs_n already low at release is never seen as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{1'(CPOL)}};
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_hist  <= 1'(CPOL);
            cs_hist   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_hist;
    assign sck_fall    = ~sck_s & sck_hist;
    assign cs_rise     = cs_s & ~cs_hist;
    assign cs_fall     = ~cs_s & cs_hist;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    assign active    = (state == ACTIVE);
    assign do_sample = active & sample_edge;
    assign word_done = do_sample & (cnt == LAST);
    assign go_active = ~active & cs_fall;
    assign go_idle   = active & cs_rise;
    assign cnt_after = word_done ? '0 : (do_sample ? cnt + 1'b1 : cnt);
    // A sample landing in the same cycle as cs_n rise completes its word before the frame ends.
    assign frame_abort = go_idle & (cnt_after != '0);
    assign shift_act   = active & shift_edge & ~cs_rise;
    assign do_load     = (CPHA == 0) ? (go_active | (shift_act & load_pend))
                                     : (shift_act & (cnt == '0));
    assign do_shift    = shift_act & ~do_load;

    assign rx_next = (LSB_FIRST != 0) ? {mosi_s, rx_shift[WIDTH-1:1]}
                                      : {rx_shift[WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load reads the buffer state before this cycle's accept, so a simultaneous accept stays buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            load_pend   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (do_load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (do_shift) begin
                tx_shift <= (LSB_FIRST != 0) ? {1'b0, tx_shift[WIDTH-1:1]}
                                             : {tx_shift[WIDTH-2:0], 1'b0};
            end

            if (go_active) begin
                cnt       <= '0;
                rx_shift  <= '0;
                load_pend <= 1'b0;
            end else if (active) begin
                if (do_load) load_pend <= 1'b0;
                if (do_sample) begin
                    rx_shift <= rx_next;
                    cnt      <= cnt_after;
                    if (word_done) begin
                        rx_data   <= rx_next;
                        rx_valid  <= 1'b1;
                        load_pend <= 1'b1;
                    end
                end
                if (go_idle) begin
                    cnt       <= '0;
                    rx_shift  <= '0;
                    load_pend <= 1'b0;
                    frame_err <= frame_abort;
                end
            end
        end
    end

    assign miso     = active ? ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[WIDTH-1]) : 1'b0;
    assign miso_oe  = active;
    assign busy     = active;
    assign tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_slave_par.sv
// Bench for spi_slave_par: a mode-0 MSB-first instance and a mode-3 LSB-first instance,
// driven by host tasks, with rx words and tx words checked against scoreboard queues.
module tb_spi_slave_par;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sck0 = 1'b0, mosi0 = 1'b0, cs_n0 = 1'b1;
    logic       miso0, miso_oe0, tx_ready0, rx_valid0, frame_err0, tx_underrun0, busy0;
    logic [7:0] tx_data0 = 8'h00, rx_data0;
    logic       tx_valid0 = 1'b0;

    logic       sck3 = 1'b1, mosi3 = 1'b0, cs_n3 = 1'b1;
    logic       miso3, miso_oe3, tx_ready3, rx_valid3, frame_err3, tx_underrun3, busy3;
    logic [7:0] tx_data3 = 8'h00, rx_data3;
    logic       tx_valid3 = 1'b0;

    int total = 0;
    int bad = 0;
    int urun0 = 0, ferr0 = 0, rxn0 = 0;
    int urun3 = 0, ferr3 = 0, rxn3 = 0;
    logic [7:0] rx_q0[$], tx_q0[$], rx_q3[$], tx_q3[$];

    spi_slave_par #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .sck(sck0), .mosi(mosi0), .cs_n(cs_n0),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .frame_err(frame_err0), .tx_underrun(tx_underrun0), .busy(busy0)
    );

    spi_slave_par #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .sck(sck3), .mosi(mosi3), .cs_n(cs_n3),
        .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data3), .tx_valid(tx_valid3),
        .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .frame_err(frame_err3), .tx_underrun(tx_underrun3), .busy(busy3)
    );

    // Received words are popped from the scoreboard as they come out of the DUT.
    always @(negedge clk) begin
        if (tx_underrun0) urun0++;
        if (frame_err0)   ferr0++;
        if (tx_underrun3) urun3++;
        if (frame_err3)   ferr3++;
        if (rx_valid0) begin
            logic [7:0] e0;
            rxn0++;
            total++;
            if (rx_q0.size() == 0) begin
                bad++;
                $display("[TB] FAIL rx0_unexpected: got %h want none", rx_data0);
            end else begin
                e0 = rx_q0.pop_front();
                if (rx_data0 !== e0) begin
                    bad++;
                    $display("[TB] FAIL rx0_word: got %h want %h", rx_data0, e0);
                end
            end
        end
        if (rx_valid3) begin
            logic [7:0] e3;
            rxn3++;
            total++;
            if (rx_q3.size() == 0) begin
                bad++;
                $display("[TB] FAIL rx3_unexpected: got %h want none", rx_data3);
            end else begin
                e3 = rx_q3.pop_front();
                if (rx_data3 !== e3) begin
                    bad++;
                    $display("[TB] FAIL rx3_word: got %h want %h", rx_data3, e3);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push0(input logic [7:0] w);
        for (int k = 0; k < 200 && !tx_ready0; k++) @(negedge clk);
        total++;
        if (tx_ready0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL push0_ready: got %b want 1", tx_ready0);
        end else begin
            tx_data0  = w;
            tx_valid0 = 1'b1;
            tx_q0.push_back(w);
            @(negedge clk);
            tx_valid0 = 1'b0;
        end
    endtask

    task automatic push3(input logic [7:0] w);
        for (int k = 0; k < 200 && !tx_ready3; k++) @(negedge clk);
        total++;
        if (tx_ready3 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL push3_ready: got %b want 1", tx_ready3);
        end else begin
            tx_data3  = w;
            tx_valid3 = 1'b1;
            tx_q3.push_back(w);
            @(negedge clk);
            tx_valid3 = 1'b0;
        end
    endtask

    // Mode-0 host word; on the frame's last word cs_n rises while sck is still high.
    task automatic word0(input logic [7:0] mo, input int nbits, input bit last);
        logic [7:0] mi, exp;
        mi = 8'h00;
        if (nbits == 8) rx_q0.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            mosi0 = mo[7-i];
            repeat (8) @(negedge clk);
            sck0 = 1'b1;
            mi[7-i] = miso0;
            repeat (8) @(negedge clk);
            if (last && i == nbits - 1) begin
                cs_n0 = 1'b1;
                repeat (2) @(negedge clk);
            end
            sck0 = 1'b0;
        end
        if (nbits == 8) begin
            total++;
            if (tx_q0.size() == 0) begin
                bad++;
                $display("[TB] FAIL miso0_word: got %h want none queued", mi);
            end else begin
                exp = tx_q0.pop_front();
                if (mi !== exp) begin
                    bad++;
                    $display("[TB] FAIL miso0_word: got %h want %h", mi, exp);
                end
            end
        end
    endtask

    task automatic word3(input logic [7:0] mo);
        logic [7:0] mi, exp;
        mi = 8'h00;
        rx_q3.push_back(mo);
        for (int i = 0; i < 8; i++) begin
            sck3  = 1'b0;
            mosi3 = mo[i];
            repeat (8) @(negedge clk);
            sck3 = 1'b1;
            mi[i] = miso3;
            repeat (8) @(negedge clk);
        end
        total++;
        if (tx_q3.size() == 0) begin
            bad++;
            $display("[TB] FAIL miso3_word: got %h want none queued", mi);
        end else begin
            exp = tx_q3.pop_front();
            if (mi !== exp) begin
                bad++;
                $display("[TB] FAIL miso3_word: got %h want %h", mi, exp);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({miso0, miso_oe0, rx_valid0, tx_ready0, frame_err0, tx_underrun0, busy0, rx_data0} !== 15'b000100000000000) begin
            bad++;
            $display("[TB] FAIL reset0_outputs: got %b want %b",
                     {miso0, miso_oe0, rx_valid0, tx_ready0, frame_err0, tx_underrun0, busy0, rx_data0}, 15'b000100000000000);
        end
        total++;
        if ({miso3, miso_oe3, rx_valid3, tx_ready3, frame_err3, tx_underrun3, busy3, rx_data3} !== 15'b000100000000000) begin
            bad++;
            $display("[TB] FAIL reset3_outputs: got %b want %b",
                     {miso3, miso_oe3, rx_valid3, tx_ready3, frame_err3, tx_underrun3, busy3, rx_data3}, 15'b000100000000000);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0();
        int u, f, n;
        push0(8'h3C);
        u = urun0; f = ferr0; n = rxn0;
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busy0 !== 1'b1 || miso_oe0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mode0_busy: got %b%b want 11", busy0, miso_oe0);
        end
        word0(8'hA5, 8, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (rxn0 - n !== 1 || urun0 - u !== 0 || ferr0 - f !== 0 || rx_q0.size() !== 0) begin
            bad++;
            $display("[TB] FAIL mode0_counts: got rx=%0d urun=%0d ferr=%0d left=%0d want 1 0 0 0",
                     rxn0 - n, urun0 - u, ferr0 - f, rx_q0.size());
        end
        total++;
        if (busy0 !== 1'b0 || miso0 !== 1'b0 || miso_oe0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mode0_idle: got %b%b%b want 000", busy0, miso0, miso_oe0);
        end
    endtask

    task automatic test_mode3_lsb();
        int u, n;
        push3(8'h96);
        u = urun3; n = rxn3;
        cs_n3 = 1'b0;
        repeat (10) @(negedge clk);
        word3(8'h01);
        repeat (8) @(negedge clk);
        cs_n3 = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (rxn3 - n !== 1 || urun3 - u !== 0 || ferr3 !== 0 || rx_q3.size() !== 0) begin
            bad++;
            $display("[TB] FAIL mode3_counts: got rx=%0d urun=%0d ferr=%0d left=%0d want 1 0 0 0",
                     rxn3 - n, urun3 - u, ferr3, rx_q3.size());
        end
        total++;
        if (rx_data3 !== 8'h01 || busy3 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mode3_rx_hold: got %h busy=%b want 01 busy=0", rx_data3, busy3);
        end
    endtask

    task automatic test_back_to_back();
        int u, n;
        push0(8'h5C);
        u = urun0; n = rxn0;
        cs_n0 = 1'b0;
        repeat (8) @(negedge clk);
        push0(8'hE1);
        word0(8'h12, 8, 1'b0);
        word0(8'h34, 8, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (rxn0 - n !== 2 || urun0 - u !== 0 || rx_q0.size() !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_counts: got rx=%0d urun=%0d left=%0d want 2 0 0",
                     rxn0 - n, urun0 - u, rx_q0.size());
        end
    endtask

    task automatic test_underrun();
        int u;
        u = urun0;
        tx_q0.push_back(8'h00);
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        word0(8'hC3, 8, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (urun0 - u !== 1) begin
            bad++;
            $display("[TB] FAIL underrun_pulses: got %0d want 1", urun0 - u);
        end
    endtask

    task automatic test_frame_err();
        int f, n;
        f = ferr0; n = rxn0;
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        word0(8'h3B, 5, 1'b0);
        cs_n0 = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (ferr0 - f !== 1 || rxn0 - n !== 0) begin
            bad++;
            $display("[TB] FAIL frame_err_pulse: got ferr=%0d rx=%0d want 1 0", ferr0 - f, rxn0 - n);
        end
        total++;
        if (rx_data0 !== 8'hC3 || busy0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL frame_err_hold: got %h busy=%b want c3 busy=0", rx_data0, busy0);
        end
        push0(8'h99);
        f = ferr0; n = rxn0;
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        word0(8'h77, 8, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (ferr0 - f !== 0 || rxn0 - n !== 1 || rx_data0 !== 8'h77) begin
            bad++;
            $display("[TB] FAIL frame_after_err: got ferr=%0d rx=%0d data=%h want 0 1 77",
                     ferr0 - f, rxn0 - n, rx_data0);
        end
    endtask

    task automatic test_reset_mid();
        int f, n;
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        word0(8'h5A, 3, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({miso0, miso_oe0, rx_valid0, tx_ready0, frame_err0, tx_underrun0, busy0, rx_data0} !== 15'b000100000000000) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got %b want %b",
                     {miso0, miso_oe0, rx_valid0, tx_ready0, frame_err0, tx_underrun0, busy0, rx_data0}, 15'b000100000000000);
        end
        f = ferr0; n = rxn0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || ferr0 - f !== 0 || rxn0 - n !== 0) begin
            bad++;
            $display("[TB] FAIL midreset_no_start: got busy=%b ferr=%0d rx=%0d want 0 0 0", busy0, ferr0 - f, rxn0 - n);
        end
        cs_n0 = 1'b1;
        repeat (10) @(negedge clk);
        cs_n0 = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_restart: got busy=%b want 1", busy0);
        end
        tx_q0.push_back(8'h00);
        word0(8'hA7, 8, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (rxn0 - n !== 1 || rx_q0.size() !== 0) begin
            bad++;
            $display("[TB] FAIL midreset_rx: got rx=%0d left=%0d want 1 0", rxn0 - n, rx_q0.size());
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_mode0();
        test_mode3_lsb();
        test_back_to_back();
        test_underrun();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
